ifft_seq_ctrl: RTL

Sequencer for the 16-point radix-2 decimation-in-frequency (DIF) IFFT core. On `start` it runs 4 butterfly stages, one butterfly per cycle, over an in-place 16-entry sample memory. Each cycle it drives the memory read and write addresses, the twiddle ROM address (`ifft_tf_rom`), and the write enables, delayed to match the butterfly pipeline. It then reads the result out in bit-reversed order and pulses `done`.

---
 rtl/ifft_seq_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ifft_seq_ctrl.sv
// ifft_seq_ctrl: address and strobe sequencer for the 16-point radix-2 DIF IFFT.
// Issues one butterfly per cycle over four stages, delays the write strobes by
// LAT cycles to line up with the butterfly pipeline, then unloads the in-place
// memory in bit-reversed order and pulses done.
module ifft_seq_ctrl #(
    parameter int LAT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [1:0] stage,
    output logic       rd_en,
    output logic [3:0] rd_addr_top,
    output logic [3:0] rd_addr_bot,
    output logic [3:0] tf_addr,
    output logic       wr_en,
    output logic [3:0] wr_addr_top,
    output logic [3:0] wr_addr_bot,
    output logic       out_rd_en,
    output logic [3:0] out_rd_addr,
    output logic       out_last
);

    // A pipeline latency outside 1..8 does not fit the drain counter.
    if (LAT < 1 || LAT > 8) begin : g_lat_error
        $error("ifft_seq_ctrl: LAT must be in 1..8");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_UNLOAD,
        S_DONE
    } state_t;

    // One slot of the write delay line: strobe plus both result addresses.
    typedef struct packed {
        logic       en;
        logic [3:0] top;
        logic [3:0] bot;
    } wr_slot_t;

    state_t     state, nxt_state;
    logic [2:0] bfly, nxt_bfly;
    logic [1:0] nxt_stage;
    logic [2:0] drain_cnt, nxt_drain_cnt;
    logic [3:0] out_idx, nxt_out_idx;

    // Butterfly addressing for the upcoming cycle.
    logic [3:0] b4, half, mask, base, addr_top, addr_bot, addr_tf;

    wr_slot_t   dly [LAT];

    // Next-state and next-counter decode; outputs are registered from these.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        nxt_state     = state;
        nxt_bfly      = bfly;
        nxt_stage     = stage;
        nxt_drain_cnt = drain_cnt;
        nxt_out_idx   = out_idx;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    nxt_state = S_RUN;
                    nxt_stage = 2'd0;
                    nxt_bfly  = 3'd0;
                end else begin
                    nxt_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (bfly == 3'd7) begin
                    nxt_state     = S_DRAIN;
                    nxt_drain_cnt = 3'd0;
                end else begin
                    nxt_bfly = bfly + 3'd1;
                end
            end
            S_DRAIN: begin
                // The last write of the stage lands in the final drain cycle;
                // the next read follows one cycle later, so no bypass is needed.
                if (drain_cnt == 3'(LAT - 1)) begin
                    if (stage == 2'd3) begin
                        nxt_state   = S_UNLOAD;
                        nxt_stage   = 2'd0;
                        nxt_out_idx = 4'd0;
                    end else begin
                        nxt_state = S_RUN;
                        nxt_stage = stage + 2'd1;
                        nxt_bfly  = 3'd0;
                    end
                end else begin
                    nxt_drain_cnt = drain_cnt + 3'd1;
                end
            end
            S_UNLOAD: begin
                if (out_idx == 4'd15) begin
                    nxt_state = S_DONE;
                end else begin
                    nxt_out_idx = out_idx + 4'd1;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Operand and twiddle addresses for butterfly nxt_bfly of stage nxt_stage.
    always_comb begin
        b4   = {1'b0, nxt_bfly};
        half = 4'd8 >> nxt_stage;
        mask = half - 4'd1;
        case (nxt_stage)
            2'd0:    base = 4'd0;
            2'd1:    base = 4'd8;
            2'd2:    base = 4'd12;
            default: base = 4'd14;
        endcase
        // Group index shifted up to the group's start, plus offset within group.
        addr_top = ((b4 >> (2'd3 - nxt_stage)) << (3'd4 - {1'b0, nxt_stage})) | (b4 & mask);
        addr_bot = addr_top + half;
        addr_tf  = base + (b4 & mask);
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            bfly        <= 3'd0;
            stage       <= 2'd0;
            drain_cnt   <= 3'd0;
            out_idx     <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr_top <= 4'd0;
            rd_addr_bot <= 4'd0;
            tf_addr     <= 4'd0;
            out_rd_en   <= 1'b0;
            out_rd_addr <= 4'd0;
            out_last    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state       <= nxt_state;
            bfly        <= nxt_bfly;
            stage       <= nxt_stage;
            drain_cnt   <= nxt_drain_cnt;
            out_idx     <= nxt_out_idx;
            busy        <= (nxt_state == S_RUN) || (nxt_state == S_DRAIN) || (nxt_state == S_UNLOAD);
            done        <= (nxt_state == S_DONE);
            rd_en       <= (nxt_state == S_RUN);
            rd_addr_top <= (nxt_state == S_RUN) ? addr_top : 4'd0;
            rd_addr_bot <= (nxt_state == S_RUN) ? addr_bot : 4'd0;
            tf_addr     <= (nxt_state == S_RUN) ? addr_tf  : 4'd0;
            out_rd_en   <= (nxt_state == S_UNLOAD);
            out_rd_addr <= (nxt_state == S_UNLOAD) ?
                           {nxt_out_idx[0], nxt_out_idx[1], nxt_out_idx[2], nxt_out_idx[3]} : 4'd0;
            out_last    <= (nxt_state == S_UNLOAD) && (nxt_out_idx == 4'd15);
        end
    end

    // Write delay line: read strobe and addresses delayed by LAT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this small delay line is reset deliberately so no stale write strobe escapes after reset.
            for (int i = 0; i < LAT; i++) begin
                dly[i] <= '0;
            end
        end else begin
            dly[0] <= '{en: rd_en, top: rd_addr_top, bot: rd_addr_bot};
            for (int i = 1; i < LAT; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign wr_en       = dly[LAT-1].en;
    assign wr_addr_top = dly[LAT-1].top;
    assign wr_addr_bot = dly[LAT-1].bot;

endmodule
